uni_buf_loader: RTL and testbench

- Responder for the controller's unified-buffer command interface: accepts one load/store command (type, external base address, row x col element block, buffer base address), then moves the block between external memory and the unified-buffer SRAM, one element at a time.
- Sits between ctrl and the unified buffer SRAM / external memory port. Reports uni_ready/uni_busy back to ctrl.

---
 rtl/tinyacc_pkg.sv | 18 +
 rtl/uni_addr_gen.sv | 63 ++++++
 rtl/uni_buf_loader.sv | 159 +++++++++++++++
 tb/tb_uni_buf_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyacc_pkg.sv
// Shared types and constants for the unified-buffer loader and its address walker.
package tinyacc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_REQ  = 3'd1,
      LD_WAIT = 3'd2,
      ST_RD   = 3'd3,
      ST_WAIT = 3'd4,
      ST_REQ  = 3'd5,
      DONE    = 3'd6
   } uni_state_e;

   localparam logic UNI_TYPE_LOAD  = 1'b0;
   localparam logic UNI_TYPE_STORE = 1'b1;
   localparam int   ELEM_CNT_W     = 20;

endpackage

// File: rtl/uni_addr_gen.sv
// Row-major element walker: accumulates the external byte address and the buffer word
// address for the current element and flags when it is the final element of the block.
module uni_addr_gen
   import tinyacc_pkg::*;
#(
   parameter int BUF_AW     = 16,
   parameter int ELEM_BYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [31:0]       init_ext,
   input  logic [BUF_AW-1:0] init_buf,
   input  logic [9:0]        init_col,
   input  logic [9:0]        init_row,
   input  logic              step,
   output logic [31:0]       ext_addr,
   output logic [BUF_AW-1:0] buf_addr,
   output logic              last
);

   logic [31:0]           ext_q, ext_d;
   logic [BUF_AW-1:0]     buf_q, buf_d;
   logic [ELEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [ELEM_CNT_W-1:0] total_q, total_d;

   always_comb begin
      ext_d   = ext_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      if (init) begin
         ext_d   = init_ext;
         buf_d   = init_buf;
         cnt_d   = '0;
         // 1023 x 1023 still fits the element counter width.
         total_d = ELEM_CNT_W'(init_row) * ELEM_CNT_W'(init_col);
      end else if (step) begin
         ext_d = ext_q + 32'(ELEM_BYTES);
         buf_d = buf_q + BUF_AW'(1);
         cnt_d = cnt_q + ELEM_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ext_q   <= '0;
         buf_q   <= '0;
         cnt_q   <= '0;
         total_q <= '0;
      end else begin
         ext_q   <= ext_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
      end
   end

   assign ext_addr = ext_q;
   assign buf_addr = buf_q;
   assign last     = ((cnt_q + ELEM_CNT_W'(1)) == total_q);

endmodule

// File: rtl/uni_buf_loader.sv
// uni_buf_loader: executes one unified-buffer load/store command one element at a time.
// Defining UNI_LOADER_PERF_EN adds the perf_stall stall-cycle counter output.
module uni_buf_loader
   import tinyacc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int BUF_AW     = 16,
   parameter int ELEM_BYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              uni_load,
   input  logic              uni_type,
   input  logic [31:0]       uni_init_addr,
   input  logic [9:0]        uni_col,
   input  logic [9:0]        uni_row,
   input  logic [31:0]       uni_out_addr,
   output logic              uni_ready,
   output logic              uni_busy,
   output logic              uni_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              buf_en,
   output logic              buf_we,
   output logic [BUF_AW-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_wdata,
   input  logic [DATA_W-1:0] buf_rdata,
   output uni_state_e        dbg_state
`ifdef UNI_LOADER_PERF_EN
   ,
   output logic [31:0]       perf_stall
`endif
);

   // Handshake: mem_req/mem_we/mem_addr/mem_wdata stay constant until the cycle mem_gnt=1
   // (transfer), and for a read exactly one mem_rvalid follows in a later cycle.
   uni_state_e        state_q, state_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              capture, step, last;
   logic              unused_out_hi;

   assign unused_out_hi = ^uni_out_addr[31:BUF_AW];

   uni_addr_gen #(
      .BUF_AW     (BUF_AW),
      .ELEM_BYTES (ELEM_BYTES)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .init     (capture),
      .init_ext (uni_init_addr),
      .init_buf (uni_out_addr[BUF_AW-1:0]),
      .init_col (uni_col),
      .init_row (uni_row),
      .step     (step),
      .ext_addr (mem_addr),
      .buf_addr (buf_addr),
      .last     (last)
   );

   always_comb begin
      state_d   = state_q;
      wdata_d   = wdata_q;
      capture   = 1'b0;
      step      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      buf_en    = 1'b0;
      buf_we    = 1'b0;
      buf_wdata = '0;
      uni_done  = 1'b0;
      case (state_q)
         IDLE: begin
            if (uni_load) begin
               capture = 1'b1;
               if (uni_row == 10'd0 || uni_col == 10'd0) state_d = DONE;
               else if (uni_type == UNI_TYPE_STORE)      state_d = ST_RD;
               else                                      state_d = LD_REQ;
            end
         end
         LD_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) state_d = LD_WAIT;
         end
         LD_WAIT: begin
            if (mem_rvalid) begin
               buf_en    = 1'b1;
               buf_we    = 1'b1;
               buf_wdata = mem_rdata;
               step      = 1'b1;
               state_d   = last ? DONE : LD_REQ;
            end
         end
         ST_RD: begin
            buf_en  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wdata_d = buf_rdata;
            state_d = ST_REQ;
         end
         ST_REQ: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_gnt) begin
               step    = 1'b1;
               state_d = last ? DONE : ST_RD;
            end
         end
         DONE: begin
            uni_done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
      end
   end

   assign uni_ready = (state_q == IDLE);
   assign uni_busy  = !uni_ready;
   assign mem_wdata = wdata_q;
   assign dbg_state = state_q;

`ifdef UNI_LOADER_PERF_EN
   logic [31:0] perf_q, perf_d;
   logic        stall_cycle;

   // Counts cycles waiting on the external port: ungranted requests and missing read data.
   assign stall_cycle = (mem_req && !mem_gnt) || (state_q == LD_WAIT && !mem_rvalid);

   always_comb begin
      perf_d = perf_q;
      if (capture)                          perf_d = '0;
      else if (stall_cycle && perf_q != '1) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_uni_buf_loader.sv
// Testbench for uni_buf_loader: randomized external-port stalls against an element-index model.
module tb_uni_buf_loader;

   localparam int DATA_W = 32;
   localparam int BUF_AW = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              uni_load = 1'b0;
   logic              uni_type = 1'b0;
   logic [31:0]       uni_init_addr = '0;
   logic [9:0]        uni_col = '0;
   logic [9:0]        uni_row = '0;
   logic [31:0]       uni_out_addr = '0;
   logic              uni_ready, uni_busy, uni_done;
   logic              mem_req, mem_we;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              buf_en, buf_we;
   logic [BUF_AW-1:0] buf_addr;
   logic [DATA_W-1:0] buf_wdata;
   logic [DATA_W-1:0] buf_rdata = '0;
   logic [2:0]        dbg_state;
`ifdef UNI_LOADER_PERF_EN
   logic [31:0]       perf_stall;
`endif

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   uni_buf_loader #(.DATA_W(DATA_W), .BUF_AW(BUF_AW), .ELEM_BYTES(4)) dut (
      .clk(clk), .reset(reset),
      .uni_load(uni_load), .uni_type(uni_type), .uni_init_addr(uni_init_addr),
      .uni_col(uni_col), .uni_row(uni_row), .uni_out_addr(uni_out_addr),
      .uni_ready(uni_ready), .uni_busy(uni_busy), .uni_done(uni_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .buf_en(buf_en), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
      .buf_rdata(buf_rdata), .dbg_state(dbg_state)
`ifdef UNI_LOADER_PERF_EN
      , .perf_stall(perf_stall)
`endif
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] obs_bwa_q[$], obs_bwd_q[$];
   logic [31:0] obs_mwa_q[$], obs_mwd_q[$];
   logic [31:0] obs_bra_q[$];
   int done_cnt, req_cycles, buf_cycles, rb_bad, unstable, stall_cnt;
   int gnt_max = 0;
   int rv_max = 0;
   logic [31:0] sram [0:65535];

   // External memory contents as a fixed function of the byte address.
   function automatic logic [31:0] ext_model(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5EED_0000;
   endfunction

   // ---------------- monitor (negedge) ----------------
   logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0, p_wd = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            if (uni_ready === uni_busy) rb_bad++;
            if (uni_done) done_cnt++;
            if (mem_req) req_cycles++;
            if (buf_en) buf_cycles++;
            if (buf_en && buf_we) begin
               obs_bwa_q.push_back(32'(buf_addr));
               obs_bwd_q.push_back(buf_wdata);
            end
            if (buf_en && !buf_we) obs_bra_q.push_back(32'(buf_addr));
            if (mem_req && mem_gnt && mem_we) begin
               obs_mwa_q.push_back(mem_addr);
               obs_mwd_q.push_back(mem_wdata);
            end
            if (p_req && !p_gnt && mem_req &&
                (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wd)))
               unstable++;
         end
         p_req  = reset && mem_req;
         p_gnt  = mem_gnt;
         p_we   = mem_we;
         p_addr = mem_addr;
         p_wd   = mem_wdata;
      end
   end

   // ---------------- external memory + SRAM responder ----------------
   int          gw = -1;
   int          rv_w = 0;
   logic        rv_pend = 1'b0;
   logic [31:0] rv_data = '0;
   logic        prev_rd = 1'b0;
   logic [15:0] prev_ra = '0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         buf_rdata  = prev_rd ? sram[prev_ra] : $urandom;
         prev_rd    = reset && buf_en && !buf_we;
         prev_ra    = buf_addr;
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (!reset) begin
            gw      = -1;
            rv_pend = 1'b0;
         end else if (mem_req) begin
            if (gw < 0) gw = $urandom_range(0, gnt_max);
            if (gw == 0) begin
               mem_gnt = 1'b1;
               gw      = -1;
               if (!mem_we) begin
                  rv_pend = 1'b1;
                  rv_w    = $urandom_range(0, rv_max);
                  rv_data = ext_model(mem_addr);
               end
            end else begin
               gw--;
               stall_cnt++;
            end
         end else if (rv_pend) begin
            if (rv_w == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rv_data;
               rv_pend    = 1'b0;
            end else begin
               rv_w--;
               stall_cnt++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      exp_q.delete(); exp_addr_q.delete();
      obs_bwa_q.delete(); obs_bwd_q.delete();
      obs_mwa_q.delete(); obs_mwd_q.delete(); obs_bra_q.delete();
      done_cnt = 0; req_cycles = 0; buf_cycles = 0; rb_bad = 0; unstable = 0; stall_cnt = 0;
   endtask

   task automatic issue_cmd(input logic t, input logic [31:0] ia, input logic [9:0] c,
                            input logic [9:0] r, input logic [31:0] oa);
      @(posedge clk); #1;
      uni_load = 1'b1; uni_type = t; uni_init_addr = ia;
      uni_col = c; uni_row = r; uni_out_addr = oa;
      @(posedge clk); #1;
      uni_load = 1'b0; uni_type = 1'($urandom); uni_init_addr = $urandom;
      uni_col = 10'($urandom); uni_row = 10'($urandom); uni_out_addr = $urandom;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int start;
      start = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(posedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (uni_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", uni_ready); end
      checks++; if (uni_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", uni_busy); end
      checks++; if (uni_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", uni_done); end
      checks++; if ({mem_req, mem_we, buf_en, buf_we} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {mem_req, mem_we, buf_en, buf_we}); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      checks++; if (buf_addr !== 16'h0) begin failures++; $display("FAIL reset_buf_addr got=%h exp=0", buf_addr); end
      checks++; if (buf_wdata !== 32'h0) begin failures++; $display("FAIL reset_buf_wdata got=%h exp=0", buf_wdata); end
      reset = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_load(input string name, input logic [31:0] ia, input logic [9:0] c,
                            input logic [9:0] r, input logic [31:0] oa);
      bit ok;
      int n;
      clear_logs();
      issue_cmd(1'b0, ia, c, r, oa);
      wait_done(2000, ok);
      n = int'(c) * int'(r);
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(32'((oa + 32'(i)) & 32'hFFFF));
         exp_q.push_back(ext_model(ia + 32'(i) * 32'd4));
      end
      checks++; if (!ok) begin failures++; $display("FAIL %s_done_timeout got=none exp=pulse", name); end
      checks++;
      if (obs_bwa_q.size() != exp_q.size()) begin
         failures++; $display("FAIL %s_write_count got=%0d exp=%0d", name, obs_bwa_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_bwa_q[i] !== exp_addr_q[i] || obs_bwd_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL %s_write[%0d] got=%h/%h exp=%h/%h", name, i, obs_bwa_q[i], obs_bwd_q[i], exp_addr_q[i], exp_q[i]);
            end
         end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt); end
      checks++; if (rb_bad != 0) begin failures++; $display("FAIL %s_ready_busy got=%0d exp=0", name, rb_bad); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL %s_req_stable got=%0d exp=0", name, unstable); end
      checks++; if (obs_mwa_q.size() != 0) begin failures++; $display("FAIL %s_no_mem_write got=%0d exp=0", name, obs_mwa_q.size()); end
`ifdef UNI_LOADER_PERF_EN
      checks++; if (perf_stall !== 32'(stall_cnt)) begin failures++; $display("FAIL %s_perf got=%0d exp=%0d", name, perf_stall, stall_cnt); end
`endif
   endtask

   task automatic test_store(input string name, input logic [31:0] ia, input logic [9:0] c,
                             input logic [9:0] r, input logic [31:0] oa);
      bit ok;
      int n;
      clear_logs();
      n = int'(c) * int'(r);
      for (int i = 0; i < n; i++) sram[16'(oa + 32'(i))] = $urandom;
      issue_cmd(1'b1, ia, c, r, oa);
      wait_done(2000, ok);
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(ia + 32'(i) * 32'd4);
         exp_q.push_back(sram[16'(oa + 32'(i))]);
      end
      checks++; if (!ok) begin failures++; $display("FAIL %s_done_timeout got=none exp=pulse", name); end
      checks++;
      if (obs_mwa_q.size() != n || obs_bra_q.size() != n) begin
         failures++; $display("FAIL %s_counts got=%0d/%0d exp=%0d", name, obs_mwa_q.size(), obs_bra_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_mwa_q[i] !== exp_addr_q[i] || obs_mwd_q[i] !== exp_q[i] ||
                obs_bra_q[i] !== 32'((oa + 32'(i)) & 32'hFFFF)) begin
               failures++;
               $display("FAIL %s_elem[%0d] got=%h/%h rd=%h exp=%h/%h", name, i, obs_mwa_q[i], obs_mwd_q[i], obs_bra_q[i], exp_addr_q[i], exp_q[i]);
            end
         end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt); end
      checks++; if (obs_bwa_q.size() != 0) begin failures++; $display("FAIL %s_no_buf_write got=%0d exp=0", name, obs_bwa_q.size()); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL %s_req_stable got=%0d exp=0", name, unstable); end
`ifdef UNI_LOADER_PERF_EN
      checks++; if (perf_stall !== 32'(stall_cnt)) begin failures++; $display("FAIL %s_perf got=%0d exp=%0d", name, perf_stall, stall_cnt); end
`endif
   endtask

   task automatic test_zero_size();
      bit seen;
      clear_logs();
      issue_cmd(1'b0, 32'h3000, 10'd5, 10'd0, 32'h40);
      seen = 1'b0;
      for (int i = 0; i < 3 && !seen; i++) begin
         if (uni_done === 1'b1) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL zero_done got=none exp=pulse"); end
      @(posedge clk); #1;
      checks++; if (uni_ready !== 1'b1 || uni_done !== 1'b0) begin failures++; $display("FAIL zero_ready_after got=%0b/%0b exp=1/0", uni_ready, uni_done); end
      repeat (3) @(posedge clk);
      checks++; if (req_cycles != 0 || buf_cycles != 0) begin failures++; $display("FAIL zero_no_access got=%0d/%0d exp=0/0", req_cycles, buf_cycles); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_busy_ignore_wrap();
      bit ok;
      logic [31:0] ia;
      gnt_max = 2; rv_max = 2;
      clear_logs();
      ia = $urandom & 32'hFFFF_FFFC;
      issue_cmd(1'b0, ia, 10'd4, 10'd4, 32'h0000_FFFE);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (uni_busy !== 1'b1) begin failures++; $display("FAIL busy_before_pulse got=%0b exp=1", uni_busy); end
      uni_load = 1'b1; uni_type = 1'b1; uni_col = 10'd2; uni_row = 10'd2; uni_out_addr = 32'h100;
      @(posedge clk); #1;
      uni_load = 1'b0;
      wait_done(2000, ok);
      repeat (20) @(posedge clk);
      for (int i = 0; i < 16; i++) begin
         exp_addr_q.push_back(32'((32'hFFFE + 32'(i)) & 32'hFFFF));
         exp_q.push_back(ext_model(ia + 32'(i) * 32'd4));
      end
      checks++; if (!ok) begin failures++; $display("FAIL wrap_done_timeout got=none exp=pulse"); end
      checks++;
      if (obs_bwa_q.size() != 16) begin
         failures++; $display("FAIL wrap_write_count got=%0d exp=16", obs_bwa_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs_bwa_q[i] !== exp_addr_q[i] || obs_bwd_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL wrap_write[%0d] got=%h/%h exp=%h/%h", i, obs_bwa_q[i], obs_bwd_q[i], exp_addr_q[i], exp_q[i]);
            end
         end
      end
      checks++; if (done_cnt != 1 || obs_mwa_q.size() != 0) begin failures++; $display("FAIL wrap_second_ignored got=%0d/%0d exp=1/0", done_cnt, obs_mwa_q.size()); end
      checks++; if (uni_ready !== 1'b1) begin failures++; $display("FAIL wrap_idle_after got=%0b exp=1", uni_ready); end
   endtask

   task automatic test_reset_mid();
      bit reached;
      gnt_max = 1; rv_max = 1;
      clear_logs();
      issue_cmd(1'b0, 32'h5000, 10'd4, 10'd4, 32'h200);
      reached = 1'b0;
      for (int i = 0; i < 500 && !reached; i++) begin
         @(posedge clk); #1;
         if (obs_bwa_q.size() >= 5) reached = 1'b1;
      end
      checks++; if (!reached) begin failures++; $display("FAIL mid_progress got=%0d exp=5", obs_bwa_q.size()); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (uni_ready !== 1'b1 || mem_req !== 1'b0 || buf_en !== 1'b0) begin failures++; $display("FAIL mid_abort got=%0b/%0b/%0b exp=1/0/0", uni_ready, mem_req, buf_en); end
      reset = 1'b1;
      repeat (8) @(posedge clk);
      checks++; if (done_cnt != 0 || obs_bwa_q.size() != 5) begin failures++; $display("FAIL mid_no_done got=%0d/%0d exp=0/5", done_cnt, obs_bwa_q.size()); end
      test_load("after_reset", 32'h0000_7770, 10'd1, 10'd1, 32'h0000_0033);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      clear_logs();
      test_reset();
      gnt_max = 0; rv_max = 0;
      test_load("load_2x3", 32'h1000, 10'd3, 10'd2, 32'h20);
      test_store("store_1x4", 32'h2000, 10'd4, 10'd1, 32'h10);
      test_zero_size();
      gnt_max = 5; rv_max = 5;
      for (int k = 0; k < 3; k++)
         test_load("stall_load_3x3", $urandom & 32'hFFFF_FFFC, 10'd3, 10'd3, 32'($urandom_range(0, 65535)));
      for (int k = 0; k < 3; k++)
         test_store("stall_store", $urandom, 10'($urandom_range(1, 4)), 10'($urandom_range(1, 4)), 32'($urandom_range(0, 65535)));
      test_busy_ignore_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
